regfile_arbiter: RTL

- Shares the single-port, 32x32 CPU register file between two requesters: A (core pipeline) and B (debug/loader).
- The register file performs either one write or one dual read per clock. It has registered read outputs and a synchronous clear.
- This block grants at most one transaction per cycle, drives the register file's control and address inputs, and returns read data with a valid strobe.
- It also sequences the register-file clear after reset and on request.

---
 rtl/regfile_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares a single-port 32x32 register file between the core
// pipeline (A) and a debug/loader port (B). The block grants at most one
// transaction per cycle, returns read data with a one-cycle valid strobe, and
// runs a one-cycle register-file clear after reset and on request.
module regfile_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    // requester A
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [ADDR_W-1:0] a_rs1,
    input  logic [ADDR_W-1:0] a_rs2,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    // requester B
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [ADDR_W-1:0] b_rs1,
    input  logic [ADDR_W-1:0] b_rs2,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    // shared read data
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    // register file side
    output logic              rf_rst,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    output logic              busy
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t state, state_nxt;
    logic   rr;          // 0: A has priority on contention, 1: B
    logic   a_pend;      // A read issued last cycle
    logic   b_pend;      // B read issued last cycle

    logic              sel_rw;
    logic [ADDR_W-1:0] sel_rd;

    // State register: reset lands in INIT so the file is always cleared first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    // Next state, grants and register-file control.
    always_comb begin
        state_nxt = state;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        busy      = 1'b0;
        rf_rst    = 1'b0;
        sel_rw    = 1'b0;
        sel_rd    = '0;
        rf_rs1    = '0;
        rf_rs2    = '0;
        rf_din    = '0;
        case (state)
            INIT: begin
                busy      = 1'b1;
                // rst also forces INIT; keep the file untouched until it drops
                rf_rst    = !rst;
                state_nxt = RUN;
            end
            RUN: begin
                if (clr) begin
                    // the clear cycle issues nothing; queued requests wait
                    state_nxt = INIT;
                end else begin
                    a_gnt = a_req && (!b_req || (FIXED_PRI != 0) || !rr);
                    b_gnt = b_req && !a_gnt;
                end
            end
            default: state_nxt = INIT;
        endcase
        if (a_gnt) begin
            sel_rw = a_rw;
            sel_rd = a_rd;
            rf_rs1 = a_rs1;
            rf_rs2 = a_rs2;
            rf_din = a_wdata;
        end else if (b_gnt) begin
            sel_rw = b_rw;
            sel_rd = b_rd;
            rf_rs1 = b_rs1;
            rf_rs2 = b_rs2;
            rf_din = b_wdata;
        end
    end

    // x0 is hardwired zero: a write to it is granted but never reaches the file.
    assign rf_rw = sel_rw && (sel_rd != '0);
    assign rf_rd = sel_rd;

    // Round-robin pointer flips to the other requester after every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rr <= 1'b0;
        else if (a_gnt) rr <= 1'b1;
        else if (b_gnt) rr <= 1'b0;
    end

    // Pending-read flags: the file's outputs are registered, so data is valid
    // exactly one cycle after a read grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_pend <= 1'b0;
            b_pend <= 1'b0;
        end else begin
            a_pend <= a_gnt && !a_rw;
            b_pend <= b_gnt && !b_rw;
        end
    end

    assign a_rvalid = a_pend;
    assign b_rvalid = b_pend;
    assign rdata1   = rf_out1;
    assign rdata2   = rf_out2;

endmodule
